dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the riscv core's load/store port: the slave end of the `rd`/`wr`/`addr`/`wr_data`/`rd_data` interface the core drives. It holds byte-addressable storage, performs byte/half/word stores with byte enables and sign/zero-extending loads, and inserts a programmable number of wait states. Completion is signalled with a one-cycle `ready` pulse, so the core can stall on multi-cycle accesses.

## Interface
- `ADDR_W`, 9, byte-address width; storage is 2^ADDR_W bytes (128 words at default)
- `WAIT_STATES`, 1, extra cycles before `ready`; legal range 0..15
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset; the clock is the only clock
- `rd`  in  1  load request; held by the core until `ready`
- `wr`  in  1  store request; held by the core until `ready`
- `addr`  in  ADDR_W  byte address, held with the request
- `size`  in  3  funct3 of the load/store opcode
- `wr_data`  in  32  store data, right-aligned
- `rd_data`  out  32  extended load result
- `ready`  out  1  one-cycle completion pulse
- `err`  out  1  misaligned-access flag; present only under `DMEM_MISALIGN_TRAP_EN`

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - If `wr` or `rd` is high, latch `addr`, `size`, `wr_data` and the request type.
  - Load the wait counter with `WAIT_STATES`.
  - Go to WAIT, or go directly to RESP if `WAIT_STATES`=0.
- **WAIT:** decrement the counter; at 0 go to RESP.
- **RESP:**
  - Perform the access and pulse `ready`.
  - Return to IDLE.
  - A request still asserted in the RESP cycle is not re-accepted; the core deasserts on `ready`.
- **rd and wr high together:** the write wins; the load is dropped and `rd_data` is unchanged.
- **Store size:**
  - 000 (SB): byte lane `addr[1:0]`.
  - 001 (SH): half lane `addr[1]`.
  - 010 (SW): full word.
  - Unwritten lanes are preserved.
- **Load size:**
  - 000 LB: sign-extend.
  - 100 LBU: zero-extend.
  - 001 LH: sign-extend.
  - 101 LHU: zero-extend.
  - 010 LW: full word.
- **Unsupported size (011, 110, 111):**
  - Memory is not modified.
  - `rd_data`=0.
  - `ready` still pulses.
- **Word index:** `addr[ADDR_W-1:2]`. There is no wrap beyond the array; the address space exactly covers the storage.
- **Reset:**
  - Outputs: `rd_data`=0, `ready`=0, `err`=0.
  - FSM returns to IDLE and the counter is cleared.
  - Storage contents are not cleared.
  - Reset mid-access abandons the access. A pending store is not committed.

## Timing
- Request to `ready` is `WAIT_STATES`+1 cycles after the request-sampling edge.
  - Example: with `WAIT_STATES`=1, `rd` sampled at edge N gives `ready` high for the cycle after edge N+2.
- `rd_data` is registered:
  - It updates on the edge that raises `ready`.
  - It holds until the next completed load.
- Store data is written on the same edge that raises `ready`.
- A load following a store to the same address in back-to-back transactions returns the new data.
- Throughput is one access per `WAIT_STATES`+2 cycles, including the IDLE acceptance cycle.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A halfword access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, is misaligned.
  - A misaligned access does not modify memory.
  - A misaligned load leaves `rd_data` unchanged.
  - `err` pulses high together with `ready`.
- `DMEM_MISALIGN_TRAP_EN` not defined:
  - The `err` port is absent.
  - The low address bits are forced to alignment: halfword uses `addr[0]`=0; word uses `addr[1:0]`=0.

## Structure
- **Shared package `dmem_pkg`:**
  - FSM state enum `dmem_state_t`.
  - funct3 localparams `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - Width constant `XLEN`=32.
- **Sub-module `dmem_array`:**
  - Synchronous byte-enabled storage with a 4-bit `be`.
  - Combinational read of the indexed word.
  - The responder performs lane selection and extension.

## Test plan
- Reset, then SW `addr`=8, `wr_data`=0xDEADBEEF; then LW `addr`=8 -> `rd_data`=0xDEADBEEF, `ready` exactly 2 cycles after each request sample (`WAIT_STATES`=1).
- SB `addr`=9 `wr_data`=0x80 over word 0x00000000; LB `addr`=9 -> 0xFFFFFF80; LBU `addr`=9 -> 0x00000080; LW `addr`=8 -> 0x00008000.
- SH `addr`=14 `wr_data`=0x1234ABCD; LHU `addr`=14 -> 0x0000ABCD; LH `addr`=14 -> 0xFFFFABCD; LW `addr`=12 -> 0xABCD0000 on a zero-initialised word.
- `rd` and `wr` high together, `addr`=20, `wr_data`=5 -> the word at 20 becomes 5, `rd_data` is unchanged, a single `ready` pulse.
- Assert `reset` low during WAIT of SW `addr`=24 `wr_data`=7 -> `ready` never pulses, word 24 keeps its old value, FSM is in IDLE after release.
- With `DMEM_MISALIGN_TRAP_EN`: LW `addr`=6 -> `err`=1 and `ready`=1 in the same cycle, `rd_data` unchanged. Without it: LW `addr`=6 returns the word at 4.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } dmem_state_t;

  // Request fields captured at acceptance (address is held separately, its width is a parameter)
  typedef struct packed {
    logic            is_wr;
    logic [2:0]      size;
    logic [XLEN-1:0] wr_data;
  } dmem_req_t;

  function automatic logic f3_supported(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core load/store port; err only exists when DMEM_MISALIGN_TRAP_EN is defined.
interface dmem_responder_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) ();

  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        size;
  logic [XLEN-1:0]   wr_data;
  logic [XLEN-1:0]   rd_data;
  logic              ready;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic              err;

  modport master (output rd, wr, addr, size, wr_data, input rd_data, ready, err);
  modport slave  (input rd, wr, addr, size, wr_data, output rd_data, ready, err);
`else
  modport master (output rd, wr, addr, size, wr_data, input rd_data, ready);
  modport slave  (input rd, wr, addr, size, wr_data, output rd_data, ready);
`endif

endinterface

// File: rtl/dmem_array.sv
// Byte-enabled word storage: synchronous write, combinational read of the indexed word.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-3:0] idx,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);

  localparam int unsigned DEPTH = 1 << (ADDR_W - 2);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states and a one-cycle ready pulse.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses on err instead of forcing alignment.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic           clk,
  input  logic           reset,
  dmem_responder_if.slave bus
);

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dmem_req_t         req_q, req_d;
  logic [ADDR_W-1:0] addr_q;
  logic              ready_q, ready_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic              accept_c;

  logic [ADDR_W-1:0] eff_addr_c;
  logic [1:0]        lane_c;
  logic              misalign_c;
  logic              mem_we_c;
  logic [3:0]        be_c;
  logic [XLEN-1:0]   wdata_c;
  logic [XLEN-1:0]   arr_rdata;
  logic [XLEN-1:0]   load_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q, err_d;

  always_comb begin
    eff_addr_c = addr_q;
    misalign_c = ((req_q.size[1:0] == 2'b01) && addr_q[0]) ||
                 ((req_q.size[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
  end

  assign bus.err = err_q;
`else
  // Without the trap the low address bits are forced to the access's natural alignment
  always_comb begin
    eff_addr_c = addr_q;
    misalign_c = 1'b0;
    if (req_q.size[1:0] == 2'b01) eff_addr_c[0]   = 1'b0;
    if (req_q.size[1:0] == 2'b10) eff_addr_c[1:0] = 2'b00;
  end
`endif

  assign lane_c = eff_addr_c[1:0];

  always_comb begin
    req_d.is_wr   = bus.wr;
    req_d.size    = bus.size;
    req_d.wr_data = bus.wr_data;
  end

  // Store lane steering
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = '0;
    case (req_q.size[1:0])
      2'b00: begin
        be_c    = 4'b0001 << lane_c;
        wdata_c = {4{req_q.wr_data[7:0]}};
      end
      2'b01: begin
        be_c    = lane_c[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{req_q.wr_data[15:0]}};
      end
      2'b10: begin
        be_c    = 4'b1111;
        wdata_c = req_q.wr_data;
      end
      default: begin
        be_c    = 4'b0000;
        wdata_c = '0;
      end
    endcase
  end

  // Load lane selection and extension
  always_comb begin
    byte_c = arr_rdata[{lane_c, 3'b000} +: 8];
    half_c = arr_rdata[{lane_c[1], 4'b0000} +: 16];
    case (req_q.size)
      F3_B:    load_c = {{24{byte_c[7]}}, byte_c};
      F3_BU:   load_c = {24'h000000, byte_c};
      F3_H:    load_c = {{16{half_c[15]}}, half_c};
      F3_HU:   load_c = {16'h0000, half_c};
      F3_W:    load_c = arr_rdata;
      default: load_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      rd_data_q <= '0;
      req_q     <= '0;
      addr_q    <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      rd_data_q <= rd_data_d;
`ifdef DMEM_MISALIGN_TRAP_EN
      err_q     <= err_d;
`endif
      if (accept_c) begin
        req_q  <= req_d;
        addr_q <= bus.addr;
      end
    end
  end

  // Next state; the access completes on the edge leaving RESP so ready/rd_data rise together
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept_c  = 1'b0;
    ready_d   = 1'b0;
    rd_data_d = rd_data_q;
    mem_we_c  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // ready_q high means the core is still holding the request just served
        if ((bus.rd || bus.wr) && !ready_q) begin
          accept_c = 1'b1;
          cnt_d    = CNT_W'(WAIT_STATES);
          state_d  = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        ready_d = 1'b1;
        if (!f3_supported(req_q.size)) begin
          rd_data_d = '0;
        end else if (misalign_c) begin
`ifdef DMEM_MISALIGN_TRAP_EN
          err_d = 1'b1;
`endif
        end else if (req_q.is_wr) begin
          mem_we_c = 1'b1;
        end else begin
          rd_data_d = load_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (mem_we_c),
    .be    (be_c),
    .idx   (eff_addr_c[ADDR_W-1:2]),
    .wdata (wdata_c),
    .rdata (arr_rdata)
  );

  assign bus.rd_data = rd_data_q;
  assign bus.ready   = ready_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_STATES=1), both DMEM_MISALIGN_TRAP_EN builds.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned WS     = 1;

  logic tb_clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  dmem_responder_if #(.ADDR_W(ADDR_W)) dbus ();

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
    .clk   (tb_clk),
    .reset (reset),
    .bus   (dbus)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction: checks request-to-ready latency and that ready drops after one cycle
  task automatic do_access(input string tag, input logic r, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [2:0] sz, input logic [31:0] wd,
                           output logic [31:0] rdat, output logic e);
    int   n;
    logic got;
    @(negedge tb_clk);
    dbus.rd      = r;
    dbus.wr      = w;
    dbus.addr    = a;
    dbus.size    = sz;
    dbus.wr_data = wd;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge tb_clk);
      #1;
      n++;
      got = dbus.ready;
    end
    rdat = dbus.rd_data;
`ifdef DMEM_MISALIGN_TRAP_EN
    e = dbus.err;
`else
    e = 1'b0;
`endif
    dbus.rd = 1'b0;
    dbus.wr = 1'b0;
    check_eq({tag, "_lat"}, 32'(n - 1), 32'(WS + 1));
    @(posedge tb_clk);
    #1;
    check_eq({tag, "_pulse"}, 32'(dbus.ready), 32'h0);
  endtask

  logic [31:0] rdat;
  logic        e;
  logic        saw_ready;

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b0;
    dbus.rd      = 1'b0;
    dbus.wr      = 1'b0;
    dbus.addr    = '0;
    dbus.size    = F3_W;
    dbus.wr_data = '0;
    repeat (2) @(negedge tb_clk);
    check_eq("rst_rd_data", dbus.rd_data, 32'h0);
    check_eq("rst_ready", 32'(dbus.ready), 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check_eq("rst_err", 32'(dbus.err), 32'h0);
`endif
    reset = 1'b1;

    // Word store / load round trip
    do_access("sw8", 1'b0, 1'b1, 9'd8, F3_W, 32'hDEADBEEF, rdat, e);
    do_access("lw8", 1'b1, 1'b0, 9'd8, F3_W, 32'h0, rdat, e);
    check_eq("lw8_data", rdat, 32'hDEADBEEF);

    // Byte store into a cleared word, then signed/unsigned byte and full word loads
    do_access("sw8z", 1'b0, 1'b1, 9'd8, F3_W, 32'h0, rdat, e);
    do_access("sb9", 1'b0, 1'b1, 9'd9, F3_B, 32'h00000080, rdat, e);
    do_access("lb9", 1'b1, 1'b0, 9'd9, F3_B, 32'h0, rdat, e);
    check_eq("lb9_data", rdat, 32'hFFFFFF80);
    do_access("lbu9", 1'b1, 1'b0, 9'd9, F3_BU, 32'h0, rdat, e);
    check_eq("lbu9_data", rdat, 32'h00000080);
    do_access("lw8b", 1'b1, 1'b0, 9'd8, F3_W, 32'h0, rdat, e);
    check_eq("lw8b_data", rdat, 32'h00008000);

    // Upper halfword store
    do_access("sw12z", 1'b0, 1'b1, 9'd12, F3_W, 32'h0, rdat, e);
    do_access("sh14", 1'b0, 1'b1, 9'd14, F3_H, 32'h1234ABCD, rdat, e);
    do_access("lhu14", 1'b1, 1'b0, 9'd14, F3_HU, 32'h0, rdat, e);
    check_eq("lhu14_data", rdat, 32'h0000ABCD);
    do_access("lh14", 1'b1, 1'b0, 9'd14, F3_H, 32'h0, rdat, e);
    check_eq("lh14_data", rdat, 32'hFFFFABCD);
    do_access("lw12", 1'b1, 1'b0, 9'd12, F3_W, 32'h0, rdat, e);
    check_eq("lw12_data", rdat, 32'hABCD0000);

    // rd and wr together: store wins, rd_data keeps the previous load
    do_access("rdwr20", 1'b1, 1'b1, 9'd20, F3_W, 32'h5, rdat, e);
    check_eq("rdwr20_rd_data", rdat, 32'hABCD0000);
    do_access("lw20", 1'b1, 1'b0, 9'd20, F3_W, 32'h0, rdat, e);
    check_eq("lw20_data", rdat, 32'h00000005);

    // Unsupported funct3: store ignored, load returns zero
    do_access("s111", 1'b0, 1'b1, 9'd8, 3'b111, 32'hFFFFFFFF, rdat, e);
    do_access("l011", 1'b1, 1'b0, 9'd8, 3'b011, 32'h0, rdat, e);
    check_eq("l011_data", rdat, 32'h0);
    do_access("lw8c", 1'b1, 1'b0, 9'd8, F3_W, 32'h0, rdat, e);
    check_eq("lw8c_data", rdat, 32'h00008000);

    // Reset during WAIT abandons the pending store
    do_access("sw24", 1'b0, 1'b1, 9'd24, F3_W, 32'h00000011, rdat, e);
    @(negedge tb_clk);
    dbus.wr      = 1'b1;
    dbus.addr    = 9'd24;
    dbus.size    = F3_W;
    dbus.wr_data = 32'h7;
    @(posedge tb_clk);
    #1;
    check_eq("rst_mid_in_wait", 32'(dut.state_q), 32'(ST_WAIT));
    reset = 1'b0;
    #1;
    check_eq("rst_mid_ready", 32'(dbus.ready), 32'h0);
    check_eq("rst_mid_rd_data", dbus.rd_data, 32'h0);
    dbus.wr = 1'b0;
    repeat (2) @(negedge tb_clk);
    reset = 1'b1;
    saw_ready = 1'b0;
    repeat (4) begin
      @(posedge tb_clk);
      #1;
      saw_ready = saw_ready | dbus.ready;
    end
    check_eq("rst_mid_no_ready", 32'(saw_ready), 32'h0);
    check_eq("rst_mid_idle", 32'(dut.state_q), 32'(ST_IDLE));
    do_access("lw24", 1'b1, 1'b0, 9'd24, F3_W, 32'h0, rdat, e);
    check_eq("lw24_data", rdat, 32'h00000011);

    // Misaligned word load at 6
    do_access("sw4", 1'b0, 1'b1, 9'd4, F3_W, 32'hCAFEF00D, rdat, e);
    do_access("lw4", 1'b1, 1'b0, 9'd4, F3_W, 32'h0, rdat, e);
    check_eq("lw4_data", rdat, 32'hCAFEF00D);
    do_access("sw4b", 1'b0, 1'b1, 9'd4, F3_W, 32'h13572468, rdat, e);
    do_access("lw6", 1'b1, 1'b0, 9'd6, F3_W, 32'h0, rdat, e);
`ifdef DMEM_MISALIGN_TRAP_EN
    check_eq("lw6_err", 32'(e), 32'h1);
    check_eq("lw6_rd_data_held", rdat, 32'hCAFEF00D);
`else
    check_eq("lw6_err", 32'(e), 32'h0);
    check_eq("lw6_aligned", rdat, 32'h13572468);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
